// File: rtl/frame_sched_ctrl.sv
// Ping-pong frame buffer write sequencer and frame encoder launcher.
// Optional stall counter is enabled by defining FRAME_SCHED_STALL_CNT_EN.
module frame_sched_ctrl #(
  parameter int SAMPLE_W  = 16,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                enable,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic                buf_we,
  output logic [ADDR_W:0]     buf_waddr,
  output logic [SAMPLE_W-1:0] buf_wdata,
  output logic                enc_start,
  output logic                enc_bank,
  input  logic                enc_done,
  output logic                busy,
  output logic [1:0]          bank_full,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         stall_cnt
);

  typedef enum logic {E_IDLE, E_RUN} enc_state_t;

  enc_state_t        state_reg;
  logic              wr_bank_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              rd_bank_reg;
  logic [1:0]        bank_full_reg;
  logic              enc_start_reg;
  logic              enc_bank_reg;
  logic              busy_reg;
  logic [15:0]       frame_cnt_reg;

  logic              accept;
  logic              frame_done;
  logic              enc_finish;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;
  logic [1:0]        bank_full_next;

  assign s_ready    = enable & ~rst & ~bank_full_reg[wr_bank_reg];
  assign accept     = s_valid & s_ready;
  assign frame_done = accept && (wr_ptr_reg == ADDR_W'(FRAME_LEN - 1));
  assign enc_finish = (state_reg == E_RUN) && enc_done;

  assign buf_we    = accept;
  assign buf_waddr = {wr_bank_reg, wr_ptr_reg};
  assign buf_wdata = s_data;

  // A bank being filled is never the bank being encoded, so set and clear never collide.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign set_mask[gi] = frame_done && (int'(wr_bank_reg) == gi);
      assign clr_mask[gi] = enc_finish && (int'(rd_bank_reg) == gi);
    end
  endgenerate

  assign bank_full_next = (bank_full_reg & ~clr_mask) | set_mask;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= E_IDLE;
      wr_bank_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_bank_reg   <= 1'b0;
      bank_full_reg <= 2'b00;
      enc_start_reg <= 1'b0;
      enc_bank_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      bank_full_reg <= bank_full_next;
      enc_start_reg <= 1'b0;

      if (accept) begin
        if (frame_done) begin
          wr_ptr_reg  <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_ptr_reg  <= wr_ptr_reg + 1'b1;
        end
      end

      case (state_reg)
        E_IDLE: begin
          // Launch only on the registered flag, giving one cycle of latency.
          if (bank_full_reg[rd_bank_reg]) begin
            enc_start_reg <= 1'b1;
            enc_bank_reg  <= rd_bank_reg;
            busy_reg      <= 1'b1;
            state_reg     <= E_RUN;
          end
        end
        E_RUN: begin
          if (enc_done) begin
            rd_bank_reg   <= ~rd_bank_reg;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            busy_reg      <= 1'b0;
            state_reg     <= E_IDLE;
          end
        end
        default: state_reg <= E_IDLE;
      endcase
    end
  end

  assign enc_start = enc_start_reg;
  assign enc_bank  = enc_bank_reg;
  assign busy      = busy_reg;
  assign bank_full = bank_full_reg;
  assign frame_cnt = frame_cnt_reg;

`ifdef FRAME_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      stall_cnt_reg <= 16'd0;
    end else if (s_valid && !s_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Directed bench for frame_sched_ctrl with FRAME_LEN=4 (two banks of four samples).
module tb_frame_sched_ctrl;

  localparam int SAMPLE_W  = 16;
  localparam int FRAME_LEN = 4;
  localparam int ADDR_W    = 2;

  logic                clk_in = 1'b0;
  logic                rst;
  logic                enable;
  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_ready;
  logic                buf_we;
  logic [ADDR_W:0]     buf_waddr;
  logic [SAMPLE_W-1:0] buf_wdata;
  logic                enc_start;
  logic                enc_bank;
  logic                enc_done;
  logic                busy;
  logic [1:0]          bank_full;
  logic [15:0]         frame_cnt;
  logic [15:0]         stall_cnt;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_stall = 0;

  frame_sched_ctrl #(
    .SAMPLE_W (SAMPLE_W),
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .buf_we   (buf_we),
    .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata),
    .enc_start(enc_start),
    .enc_bank (enc_bank),
    .enc_done (enc_done),
    .busy     (busy),
    .bank_full(bank_full),
    .frame_cnt(frame_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [SAMPLE_W-1:0] d, input logic done);
    s_valid  = v;
    s_data   = d;
    enc_done = done;
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; s_valid = 1'b0; s_data = '0; enc_done = 1'b0;
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_bank_full", 32'(bank_full), 0);
    check("rst_enc_start", 32'(enc_start), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    check("init_s_ready", 32'(s_ready), 1);
    check("init_frame_cnt", 32'(frame_cnt), 0);
    check("init_stall_cnt", 32'(stall_cnt), 0);
    check("init_enc_bank", 32'(enc_bank), 0);

    // Fill bank 0
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'(i + 1), 1'b0);
      $display("t1 sample %0d addr %0d data %0h", i, buf_waddr, buf_wdata);
      check("t1_we", 32'(buf_we), 1);
      check("t1_waddr", 32'(buf_waddr), 32'(i));
      check("t1_wdata", 32'(buf_wdata), 32'(i + 1));
      tick();
    end
    cyc(1'b0, 16'h0, 1'b0);
    check("t1_bank_full", 32'(bank_full), 1);
    check("t1_no_early_start", 32'(enc_start), 0);
    tick();
    check("t1_enc_start", 32'(enc_start), 1);
    check("t1_enc_bank", 32'(enc_bank), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_start_pulse_end", 32'(enc_start), 0);

    // Fill bank 1, then backpressure with both banks full
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'(16'h0100 + i), 1'b0);
      $display("t2 sample %0d addr %0d data %0h", i, buf_waddr, buf_wdata);
      check("t2_we", 32'(buf_we), 1);
      check("t2_waddr", 32'(buf_waddr), 32'(4 + i));
      tick();
    end
    check("t2_bank_full", 32'(bank_full), 3);
    check("t2_s_ready_low", 32'(s_ready), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'hDEAD, 1'b0);
      $display("t2 stalled offer %0d we %0b", i, buf_we);
      check("t2_stall_we", 32'(buf_we), 0);
      check("t2_stall_ready", 32'(s_ready), 0);
      tick();
    end
    exp_stall += 4;
    cyc(1'b0, 16'h0, 1'b1);
    check("t2_busy_before_done", 32'(busy), 1);
    tick();
    cyc(1'b0, 16'h0, 1'b0);
    check("t2_bank_full_after_done", 32'(bank_full), 2);
    check("t2_frame_cnt", 32'(frame_cnt), 1);
    check("t2_busy_cleared", 32'(busy), 0);
    check("t2_s_ready_back", 32'(s_ready), 1);
    tick();
    check("t2_enc_start", 32'(enc_start), 1);
    check("t2_enc_bank", 32'(enc_bank), 1);

    // Bank 0 completes in the same cycle as enc_done for bank 1
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'(16'h0020 + i), 1'b0);
      $display("t3 sample %0d addr %0d data %0h", i, buf_waddr, buf_wdata);
      check("t3_waddr", 32'(buf_waddr), 32'(i));
      tick();
    end
    cyc(1'b1, 16'h0023, 1'b1);
    $display("t3 sample 3 addr %0d data %0h with enc_done", buf_waddr, buf_wdata);
    check("t3_last_we", 32'(buf_we), 1);
    check("t3_last_waddr", 32'(buf_waddr), 3);
    check("t3_last_wdata", 32'(buf_wdata), 32'h23);
    tick();
    cyc(1'b0, 16'h0, 1'b0);
    check("t3_bank_full_swap", 32'(bank_full), 1);
    check("t3_frame_cnt", 32'(frame_cnt), 2);
    check("t3_busy", 32'(busy), 0);
    tick();
    check("t3_enc_start", 32'(enc_start), 1);
    check("t3_enc_bank", 32'(enc_bank), 0);
    cyc(1'b0, 16'h0, 1'b1);
    tick();
    cyc(1'b0, 16'h0, 1'b0);
    check("t3_bank_full_empty", 32'(bank_full), 0);
    check("t3_frame_cnt2", 32'(frame_cnt), 3);

    // Pause intake mid-frame on bank 1
    cyc(1'b1, 16'h0030, 1'b0);
    check("t4_waddr0", 32'(buf_waddr), 4);
    tick();
    cyc(1'b1, 16'h0031, 1'b0);
    check("t4_waddr1", 32'(buf_waddr), 5);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'hBEEF, 1'b0);
      $display("t4 paused cycle %0d we %0b", i, buf_we);
      check("t4_pause_we", 32'(buf_we), 0);
      check("t4_pause_start", 32'(enc_start), 0);
      tick();
    end
    exp_stall += 10;
    enable = 1'b1;
    cyc(1'b1, 16'h0032, 1'b0);
    check("t4_resume_waddr", 32'(buf_waddr), 6);
    check("t4_resume_wdata", 32'(buf_wdata), 32'h32);
    tick();
    cyc(1'b1, 16'h0033, 1'b0);
    check("t4_waddr3", 32'(buf_waddr), 7);
    check("t4_no_start", 32'(enc_start), 0);
    tick();
    cyc(1'b0, 16'h0, 1'b0);
    check("t4_bank_full", 32'(bank_full), 2);
    check("t4_no_start2", 32'(enc_start), 0);
    tick();
    check("t4_enc_start", 32'(enc_start), 1);
    check("t4_enc_bank", 32'(enc_bank), 1);
    check("t4_busy", 32'(busy), 1);

    // Both banks full and encoder busy, then reset
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'(16'h0040 + i), 1'b0);
      check("t5_waddr", 32'(buf_waddr), 32'(i));
      tick();
    end
    cyc(1'b0, 16'h0, 1'b0);
    check("t5_bank_full", 32'(bank_full), 3);
    check("t5_busy", 32'(busy), 1);
`ifdef FRAME_SCHED_STALL_CNT_EN
    check("t5_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
    check("t5_stall_cnt", 32'(stall_cnt), 0);
`endif
    rst = 1'b1;
    tick();
    $display("t5 reset applied bank_full %0b busy %0b", bank_full, busy);
    check("t5_rst_bank_full", 32'(bank_full), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_enc_start", 32'(enc_start), 0);
    check("t5_rst_enc_bank", 32'(enc_bank), 0);
    check("t5_rst_frame_cnt", 32'(frame_cnt), 0);
    check("t5_rst_stall_cnt", 32'(stall_cnt), 0);
    check("t5_rst_s_ready", 32'(s_ready), 0);
    rst = 1'b0;
    cyc(1'b0, 16'h0, 1'b1);
    tick();
    cyc(1'b0, 16'h0, 1'b0);
    check("t5_late_done_bank_full", 32'(bank_full), 0);
    check("t5_late_done_frame_cnt", 32'(frame_cnt), 0);
    check("t5_late_done_busy", 32'(busy), 0);
    check("t5_late_done_start", 32'(enc_start), 0);

    // Refill both banks and stall for five cycles
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'(16'h0050 + i), 1'b0);
      $display("t6 sample %0d addr %0d data %0h", i, buf_waddr, buf_wdata);
      check("t6_waddr", 32'(buf_waddr), 32'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h0077, 1'b0);
      check("t6_stall_we", 32'(buf_we), 0);
      tick();
    end
    cyc(1'b0, 16'h0, 1'b0);
    check("t6_bank_full", 32'(bank_full), 3);
`ifdef FRAME_SCHED_STALL_CNT_EN
    check("t6_stall_cnt", 32'(stall_cnt), 5);
`else
    check("t6_stall_cnt", 32'(stall_cnt), 0);
`endif
    $display("t6 stall_cnt %0d", stall_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
